onenet_loopback_checker: RTL and testbench



---
 rtl/onenet_chk_pkg.sv | 19 +
 rtl/prbs7_gen.sv | 27 ++
 rtl/onenet_loopback_checker.sv | 143 ++++++++++++++
 tb/tb_onenet_loopback_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/onenet_chk_pkg.sv
// Shared constants for the one-net loopback checker: FSM encodings and PRBS7 definition.
// No timing or flow control of its own; the package holds declarations only.
package onenet_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // x^7 + x^6 + 1: feedback is lfsr[6] ^ lfsr[5], output taken from lfsr[6]
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  localparam int LATENCY_MAX = 7;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 LFSR; bit_out is the current bit, next bit appears the cycle after en.
// No backpressure: load reseeds and wins over en, en advances one step per cycle.
module prbs7_gen
  import onenet_chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic bit_out
);

  logic [6:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= PRBS7_SEED;
    end else if (load) begin
      lfsr <= PRBS7_SEED;
    end else if (en) begin
      lfsr <= {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};
    end
  end

  assign bit_out = lfsr[PRBS7_TAP_HI];

endmodule

// File: rtl/onenet_loopback_checker.sv
// Drives a PRBS7 stream onto a single net and checks the looped-back bit LATENCY cycles later.
// done at start edge + 1 + num_bits + LATENCY; no backpressure, start while busy is dropped.
module onenet_loopback_checker
  import onenet_chk_pkg::*;
#(
  parameter int LATENCY     = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_bits,
  output logic                   drive,
  input  logic                   observe,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [COUNT_WIDTH-1:0] first_err_idx
);

  localparam int                   DW         = $clog2(LATENCY_MAX + 1);
  localparam logic [DW-1:0]        DRAIN_LOAD = (LATENCY > 0) ? DW'(LATENCY - 1) : '0;
  localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ALL1 = '1;

  state_t                   state;
  logic [COUNT_WIDTH-1:0]   tx_cnt;
  logic [COUNT_WIDTH-1:0]   rx_idx;
  logic [DW-1:0]            drain_cnt;
  logic                     drive_vld;
  logic                     prbs_bit;
  logic                     prbs_load;
  logic                     prbs_en;
  logic                     exp_bit;
  logic                     exp_vld;

  assign prbs_load = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign prbs_en   = (state == ST_RUN) && (tx_cnt != '0);

  prbs7_gen u_prbs (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (prbs_load),
    .en      (prbs_en),
    .bit_out (prbs_bit)
  );

  // Expected stream: drive itself when LATENCY is 0, otherwise a shift register that
  // also carries the valid flag, so DRAIN naturally pushes invalid slots behind the data.
  generate
    if (LATENCY == 0) begin : g_comb
      assign exp_bit = drive;
      assign exp_vld = drive_vld;
    end else begin : g_pipe
      logic [LATENCY-1:0] pipe_bit;
      logic [LATENCY-1:0] pipe_vld;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_bit <= '0;
          pipe_vld <= '0;
        end else begin
          pipe_bit[0] <= drive;
          pipe_vld[0] <= drive_vld;
          for (int i = 1; i < LATENCY; i++) begin
            pipe_bit[i] <= pipe_bit[i-1];
            pipe_vld[i] <= pipe_vld[i-1];
          end
        end
      end

      assign exp_bit = pipe_bit[LATENCY-1];
      assign exp_vld = pipe_vld[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tx_cnt        <= '0;
      rx_idx        <= '0;
      drain_cnt     <= '0;
      drive         <= 1'b0;
      drive_vld     <= 1'b0;
      err_count     <= '0;
      first_err_idx <= CNT_ALL1;
    end else begin
      drive     <= 1'b0;
      drive_vld <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            tx_cnt        <= num_bits;
            rx_idx        <= '0;
            err_count     <= '0;
            first_err_idx <= CNT_ALL1;
            state         <= (num_bits == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (tx_cnt != '0) begin
            drive     <= prbs_bit;
            drive_vld <= 1'b1;
            tx_cnt    <= tx_cnt - CNT_ONE;
          end else begin
            // The last bit is still on drive this cycle; with no latency it is compared now.
            drain_cnt <= DRAIN_LOAD;
            state     <= (LATENCY == 0) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (exp_vld) begin
        rx_idx <= rx_idx + CNT_ONE;
        if (exp_bit != observe) begin
          if (err_count != CNT_ALL1) begin
            err_count <= err_count + CNT_ONE;
          end
          // err_count saturates and never wraps, so zero means no mismatch seen yet
          if (err_count == '0) begin
            first_err_idx <= rx_idx;
          end
        end
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_onenet_loopback_checker.sv
// Directed bench: a LATENCY=0 checker with pass-through/tied-0 loop and a LATENCY=2
// checker behind a two-flop loop with optional inversion and single-bit flip.
module tb_onenet_loopback_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start2;
  logic [15:0] nb0, nb2;
  logic        drive0, drive2, obs0, obs2;
  logic        busy0, busy2, done0, done2, pass0, pass2;
  logic [15:0] err0, err2, fe0, fe2;

  logic        obs_mode0 = 1'b0;
  logic        inv2 = 1'b0;
  logic        flip2 = 1'b0;
  logic        d1 = 1'b0;
  logic        d2 = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [15:0] cap;

  always #5 clk = ~clk;

  assign obs0 = obs_mode0 ? 1'b0 : drive0;

  always @(posedge clk) begin
    d1 <= drive2 ^ inv2 ^ flip2;
    d2 <= d1;
  end
  assign obs2 = d2;

  onenet_loopback_checker #(.LATENCY(0), .COUNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .num_bits(nb0), .drive(drive0),
    .observe(obs0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(fe0)
  );

  onenet_loopback_checker #(.LATENCY(2), .COUNT_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_bits(nb2), .drive(drive2),
    .observe(obs2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_idx(fe2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse0(input logic [15:0] n);
    nb0 = n; start0 = 1'b1; tick; start0 = 1'b0;
  endtask

  task automatic pulse2(input logic [15:0] n);
    nb2 = n; start2 = 1'b1; tick; start2 = 1'b0;
  endtask

  // Cycles after the current point until done is seen; -1 if it never comes.
  task automatic wait_done(input int which, output int c);
    c = -1;
    for (int i = 1; i <= 400; i++) begin
      tick;
      if ((which == 0) ? done0 : done2) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; nb0 = '0; nb2 = '0;
    tick; tick;
    check("rst_done0", done0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_drive0", drive0, 0);
    check("rst_pass0", pass0, 0);
    check("rst_err0", err0, 16'h0000);
    check("rst_fe0", fe0, 16'hFFFF);
    check("rst_fe2", fe2, 16'hFFFF);
    rst_n = 1'b1;
    tick;

    // Pass-through, no latency, 10 bits
    pulse0(16'd10);
    check("pt_busy", busy0, 1);
    wait_done(0, cyc);
    check("pt_done_cyc", cyc, 11);
    check("pt_pass", pass0, 1);
    check("pt_err", err0, 16'h0000);
    check("pt_fe", fe0, 16'hFFFF);
    check("pt_busy_end", busy0, 0);

    // observe tied low: first 7 PRBS bits are all 1
    obs_mode0 = 1'b1;
    pulse0(16'd7);
    wait_done(0, cyc);
    check("t0_done_cyc", cyc, 8);
    check("t0_err", err0, 16'd7);
    check("t0_fe", fe0, 16'd0);
    check("t0_pass", pass0, 0);
    obs_mode0 = 1'b0;

    // Inverting 2-flop loop, 100 bits
    inv2 = 1'b1;
    pulse2(16'd100);
    wait_done(2, cyc);
    check("inv_done_cyc", cyc, 103);
    check("inv_err", err2, 16'd100);
    check("inv_fe", fe2, 16'd0);
    check("inv_pass", pass2, 0);
    inv2 = 1'b0;

    // Single flip on bit 5 (on drive between edges k+6 and k+7)
    pulse2(16'd20);
    repeat (6) tick;
    flip2 = 1'b1;
    tick;
    flip2 = 1'b0;
    wait_done(2, cyc);
    check("flip_done_cyc", cyc + 7, 23);
    check("flip_err", err2, 16'd1);
    check("flip_fe", fe2, 16'd5);
    check("flip_pass", pass2, 0);

    pulse2(16'd20);
    wait_done(2, cyc);
    check("clean_done_cyc", cyc, 23);
    check("clean_err", err2, 16'd0);
    check("clean_fe", fe2, 16'hFFFF);
    check("clean_pass", pass2, 1);

    // Zero-length run
    pulse0(16'd0);
    check("zero_done", done0, 1);
    check("zero_pass", pass0, 1);
    check("zero_err", err0, 16'd0);
    check("zero_drive", drive0, 0);
    check("zero_busy", busy0, 0);
    tick;
    check("zero_drive2", drive0, 0);

    // start while busy is ignored
    pulse0(16'd10);
    repeat (3) tick;
    nb0 = 16'd2; start0 = 1'b1; tick; start0 = 1'b0;
    wait_done(0, cyc);
    check("ign_done_cyc", cyc + 4, 11);
    check("ign_err", err0, 16'd0);

    // Reset mid-run with errors accumulating, then rerun from seed
    obs_mode0 = 1'b1;
    pulse0(16'd30);
    repeat (5) tick;
    check("mid_busy", busy0, 1);
    check("mid_err", err0, 16'd4);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mrst_busy", busy0, 0);
    check("mrst_done", done0, 0);
    check("mrst_drive", drive0, 0);
    check("mrst_err", err0, 16'd0);
    check("mrst_fe", fe0, 16'hFFFF);
    obs_mode0 = 1'b0;

    pulse0(16'd16);
    for (int i = 0; i < 16; i++) begin
      tick;
      cap[i] = drive0;
    end
    check("prbs_seq", cap, 16'h207F);
    wait_done(0, cyc);
    check("prbs_done_cyc", cyc, 1);
    check("prbs_pass", pass0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
